// File: rtl/load_store_unit_pkg.sv
// Shared opcode, FSM state and byte-enable definitions for the load/store unit.
// Opcode helpers classify ALU codes so every file agrees on what counts as a memory op.
package load_store_unit_pkg;

    localparam logic [5:0] ALU_SB  = 6'd18;
    localparam logic [5:0] ALU_SH  = 6'd19;
    localparam logic [5:0] ALU_SW  = 6'd20;
    localparam logic [5:0] ALU_LB  = 6'd21;
    localparam logic [5:0] ALU_LH  = 6'd22;
    localparam logic [5:0] ALU_LW  = 6'd23;
    localparam logic [5:0] ALU_LBU = 6'd24;
    localparam logic [5:0] ALU_LHU = 6'd25;

    localparam logic [3:0] MEM_BE_BYTE    = 4'b0001;
    localparam logic [3:0] MEM_BE_LO_HALF = 4'b0011;
    localparam logic [3:0] MEM_BE_HI_HALF = 4'b1100;
    localparam logic [3:0] MEM_BE_WORD    = 4'b1111;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_BUSY = 1'b1
    } lsu_state_e;

    function automatic logic is_mem_op(input logic [5:0] op);
        return op inside {ALU_SB, ALU_SH, ALU_SW, ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return op inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
    endfunction

    // Byte accesses can never be misaligned; halves need bit 0 clear, words both bits.
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (op)
            ALU_SH, ALU_LH, ALU_LHU: mis = lo[0];
            ALU_SW, ALU_LW:          mis = |lo;
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it
// according to the load opcode; full words pass through.
module lsu_load_extend
    import load_store_unit_pkg::*;
(
    input  logic [5:0]  alucode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result = rdata;
        case (alucode)
            ALU_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            ALU_LBU: result = {24'd0, byte_sel};
            ALU_LH:  result = {{16{half_sel[15]}}, half_sel};
            ALU_LHU: result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: turns one accepted load/store into a single req/ack bus transaction,
// with misalignment rejection, an ack timeout and extended load data for writeback.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  alucode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        misaligned,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    lsu_state_e    state, state_nxt;
    logic [CW-1:0] tmo_cnt;
    logic [5:0]    op_q;
    logic [1:0]    off_q;
    logic [4:0]    rd_q;
    logic          accept, misalign, ack_done, timed_out;
    logic [3:0]    be_nxt;
    logic [31:0]   wdata_nxt;
    logic [31:0]   ext_data;

    // Handshake: an op transfers when req_valid & req_ready and the code is a memory op;
    // req_ready is purely the IDLE state, so non-memory codes are simply never taken.
    assign req_ready = (state == LSU_IDLE);
    assign accept    = req_valid & req_ready & is_mem_op(alucode);
    assign misalign  = is_misaligned(alucode, addr[1:0]);
    assign ack_done  = (state == LSU_BUSY) & mem_ack;
    assign timed_out = (state == LSU_BUSY) & ~mem_ack & (tmo_cnt == TMO_LAST);
    assign stall     = (state != LSU_IDLE) | (req_valid & ~req_ready);

    lsu_load_extend u_load_extend (
        .alucode (op_q),
        .addr_lo (off_q),
        .rdata   (mem_rdata),
        .result  (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LSU_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LSU_IDLE: if (accept && !misalign)     state_nxt = LSU_BUSY;
            LSU_BUSY: if (ack_done || timed_out)   state_nxt = LSU_IDLE;
            default:                               state_nxt = LSU_IDLE;
        endcase
    end

    always_comb begin
        be_nxt    = MEM_BE_WORD;
        wdata_nxt = store_data;
        case (alucode)
            ALU_SB: begin
                be_nxt    = MEM_BE_BYTE << addr[1:0];
                wdata_nxt = {4{store_data[7:0]}};
            end
            ALU_SH: begin
                be_nxt    = addr[1] ? MEM_BE_HI_HALF : MEM_BE_LO_HALF;
                wdata_nxt = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            tmo_cnt    <= '0;
            op_q       <= '0;
            off_q      <= '0;
            rd_q       <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            if (accept) begin
                if (misalign) begin
                    resp_valid <= 1'b1;
                    misaligned <= 1'b1;
                end else begin
                    mem_req   <= 1'b1;
                    mem_we    <= ~is_load(alucode);
                    mem_addr  <= {addr[31:2], 2'b00};
                    mem_be    <= be_nxt;
                    mem_wdata <= wdata_nxt;
                    op_q      <= alucode;
                    off_q     <= addr[1:0];
                    rd_q      <= rd_in;
                    tmo_cnt   <= '0;
                end
            end else if (ack_done) begin
                // An ack on the last counted cycle still completes normally.
                mem_req    <= 1'b0;
                resp_valid <= 1'b1;
                if (is_load(op_q)) begin
                    resp_data <= ext_data;
                    resp_rd   <= rd_q;
                end
            end else if (timed_out) begin
                mem_req    <= 1'b0;
                resp_valid <= 1'b1;
                bus_err    <= 1'b1;
            end else if (state == LSU_BUSY) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized ops checked against a
// behavioural model of bus fields and writeback responses.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int TMO = 4;

    logic        clk, rst;
    logic        req_valid, req_ready;
    logic [5:0]  alucode;
    logic [31:0] addr, store_data;
    logic [4:0]  rd_in;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        misaligned, bus_err;

    int checks = 0;
    int failures = 0;
    logic [36:0] exp_q[$];

    typedef struct {
        logic        misal;
        logic        tmo;
        logic        we;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .alucode(alucode), .addr(addr), .store_data(store_data), .rd_in(rd_in),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
        .misaligned(misaligned), .bus_err(bus_err)
    );

    // ---------------- clock / reset / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] a,
                                   input logic [31:0] sd, input logic [4:0] rd,
                                   input logic [31:0] rdata, input int ack_at);
        exp_t e;
        int unsigned bo;
        logic [7:0]  b8;
        logic [15:0] h16;
        bo = a % 4;
        e.maddr = a - bo;
        e.we    = (op == ALU_SB || op == ALU_SH || op == ALU_SW);
        e.be    = 4'hF;
        e.wdata = sd;
        e.misal = 1'b0;
        if (op == ALU_SH || op == ALU_LH || op == ALU_LHU) e.misal = (a % 2) != 0;
        if (op == ALU_SW || op == ALU_LW) e.misal = bo != 0;
        if (op == ALU_SB) begin
            e.be    = 4'(1 << bo);
            e.wdata = 32'(sd[7:0]) * 32'h0101_0101;
        end
        if (op == ALU_SH) begin
            e.be    = (bo >= 2) ? 4'hC : 4'h3;
            e.wdata = 32'(sd[15:0]) * 32'h0001_0001;
        end
        e.tmo  = !e.misal && (ack_at >= TMO);
        b8     = 8'(rdata >> (8 * bo));
        h16    = 16'(rdata >> (8 * (bo & 2)));
        e.data = 32'd0;
        e.rd   = 5'd0;
        if (!e.misal && !e.tmo && !e.we) begin
            e.rd = rd;
            case (op)
                ALU_LB:  e.data = 32'($signed(b8));
                ALU_LBU: e.data = 32'(b8);
                ALU_LH:  e.data = 32'($signed(h16));
                ALU_LHU: e.data = 32'(h16);
                default: e.data = rdata;
            endcase
        end
        return e;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_resp(input string tag);
        logic [36:0] want;
        checks++;
        assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check(tag, {27'd0, resp_rd, resp_data}, {27'd0, want});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bus"}, {mem_req, mem_we, mem_be, mem_addr, stall}, 64'd0);
        check({tag, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
        check({tag, "_resp"}, {resp_valid, misaligned, bus_err, resp_rd, resp_data}, 64'd0);
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge; ack_at = BUSY cycle index carrying mem_ack,
    // ack_at >= TMO means the bus never answers.
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] rd, input logic [31:0] rdata, input int ack_at);
        exp_t e;
        e = model(op, a, sd, rd, rdata, ack_at);
        check("req_ready", {63'd0, req_ready}, 64'd1);
        alucode = op; addr = a; store_data = sd; rd_in = rd; req_valid = 1'b1;
        #1 check("accept_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        alucode = 6'($urandom); addr = $urandom; store_data = $urandom; rd_in = 5'($urandom);
        exp_q.push_back({e.rd, e.data});
        if (e.misal) begin
            check("misal_flags", {mem_req, resp_valid, misaligned, bus_err, stall}, 64'b01100);
            check_resp("misal_resp");
            return;
        end
        for (int k = 0; k <= TMO; k++) begin
            if (k == TMO) begin
                check("tmo_flags", {mem_req, resp_valid, misaligned, bus_err, stall}, 64'b01010);
                check_resp("tmo_resp");
                break;
            end
            check("busy_flags", {mem_req, resp_valid, stall, mem_we}, {61'd0, 2'b10, 1'b1, e.we});
            check("busy_addr_be", {28'd0, mem_be, mem_addr}, {28'd0, e.be, e.maddr});
            check("busy_resp_zero", {27'd0, resp_rd, resp_data}, 64'd0);
            if (e.we) check("busy_wdata", {32'd0, mem_wdata}, {32'd0, e.wdata});
            if (k == ack_at) begin
                mem_ack = 1'b1; mem_rdata = rdata;
                @(negedge clk);
                mem_ack = 1'b0; mem_rdata = $urandom;
                check("ack_flags", {mem_req, resp_valid, misaligned, bus_err, stall}, 64'b01000);
                check_resp("ack_resp");
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [5:0] ops[8] = '{ALU_SB, ALU_SH, ALU_SW, ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};

    initial begin
        rst = 1'b1; req_valid = 1'b0; alucode = '0; addr = '0; store_data = '0;
        rd_in = '0; mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        check_all_zero("reset");
        check("reset_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // directed cases
        run_op(ALU_SW, 32'h100, 32'hDEAD_BEEF, 5'd3, 32'h0, 2);
        run_op(ALU_SB, 32'h103, 32'h0000_00A5, 5'd4, 32'h0, 0);
        run_op(ALU_LB, 32'h101, 32'h1234_5678, 5'd5, 32'h0000_8000, 1);
        run_op(ALU_LBU, 32'h101, 32'h0, 5'd6, 32'h0000_8000, 0);
        run_op(ALU_LH, 32'h102, 32'h0, 5'd7, 32'h8001_0000, 0);
        run_op(ALU_LW, 32'h102, 32'h0, 5'd8, 32'h0, 0);
        run_op(ALU_SH, 32'h101, 32'h1234, 5'd9, 32'h0, 0);
        run_op(ALU_LW, 32'h104, 32'h0, 5'd10, 32'h0, TMO);
        run_op(ALU_LW, 32'h108, 32'h0, 5'd11, 32'hCAFE_F00D, TMO - 1);

        // non-memory code: never accepted, no stall, no response
        alucode = 6'd0; req_valid = 1'b1;
        #1 check("nonmem_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("nonmem_idle", {mem_req, resp_valid, req_ready}, 64'b001);

        // reset mid-transaction, then a late ack in IDLE
        alucode = ALU_LW; addr = 32'h200; rd_in = 5'd12; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_req", {63'd0, mem_req}, 64'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack", {mem_req, resp_valid, stall}, 64'd0);
        run_op(ALU_LW, 32'h200, 32'h0, 5'd12, 32'h0BAD_F00D, 1);

        // randomized traffic, back-to-back and with gaps
        for (int n = 0; n < 80; n++) begin
            logic [5:0]  op;
            logic [31:0] a;
            op = ops[$urandom_range(0, 7)];
            a  = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_op(op, a, $urandom, 5'($urandom_range(1, 31)), $urandom, $urandom_range(0, TMO));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check("gap_idle", {mem_req, resp_valid, stall}, 64'd0);
            end
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
